// File: rtl/zstr_fifo.sv
// zstr_fifo: parametrised z-stream buffer between a zstr source and drain.
// Stores up to QL words of BW bits and replays them in order. It also reports
// occupancy and an almost-full flag.
//
// Ports:
//   clk    in  1   system clock, rising edge
//   rst    in  1   synchronous active-high reset
//   s_vld  in  1   slave transfer valid
//   s_bus  in  BW  slave data
//   s_rdy  out 1   slave ready (registered state gated by rst only)
//   m_vld  out 1   master transfer valid
//   m_bus  out BW  master data (XZ while m_vld is 0)
//   m_rdy  in  1   master ready
//   cnt    out CW  number of stored words, 0..QL
//   afull  out 1   cnt >= AF
module zstr_fifo #(
    parameter int unsigned    BW = 8,
    parameter logic [BW-1:0]  XZ = {BW{1'bx}},
    parameter int unsigned    QL = 4,
    parameter int unsigned    QW = (QL > 1) ? $clog2(QL) : 1,
    parameter int unsigned    CW = $clog2(QL + 1),
    parameter int unsigned    AF = QL - 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_vld,
    input  logic [BW-1:0] s_bus,
    output logic          s_rdy,
    output logic          m_vld,
    output logic [BW-1:0] m_bus,
    input  logic          m_rdy,
    output logic [CW-1:0] cnt,
    output logic          afull
);

    logic [BW-1:0] mem [QL];
    logic [QW-1:0] wp;
    logic [QW-1:0] rp;
    logic [QW-1:0] wp_d;
    logic [QW-1:0] rp_d;
    logic [CW-1:0] cnt_d;
    logic          push;
    logic          pop;

    // Status decode from registered state only; s_rdy has no path from m_rdy.
    assign s_rdy = !rst && (cnt != CW'(QL));
    assign m_vld = (cnt != '0);
    assign m_bus = m_vld ? mem[rp] : XZ;
    assign afull = (cnt >= CW'(AF));

    assign push = s_vld & s_rdy;
    assign pop  = m_vld & m_rdy;

    // Next pointer and count; explicit wrap so QL need not be a power of two.
    always_comb begin
        wp_d  = wp;
        rp_d  = rp;
        cnt_d = cnt;
        if (push) begin
            wp_d = (wp == QW'(QL - 1)) ? '0 : wp + QW'(1);
        end
        if (pop) begin
            rp_d = (rp == QW'(QL - 1)) ? '0 : rp + QW'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt + CW'(1);
            2'b01:   cnt_d = cnt - CW'(1);
            default: cnt_d = cnt;
        endcase
    end

    // Pointer and count registers; reset discards contents and any pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            wp  <= wp_d;
            rp  <= rp_d;
            cnt <= cnt_d;
        end
    end

    // Storage write; push is already blocked while rst is high.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= s_bus;
        end
    end

endmodule

// File: tb/tb_zstr_fifo.sv
// Directed bench for zstr_fifo (BW=8, QL=4, AF=3). Stimulus pushes hand-chosen
// words into a scoreboard queue after each edge where they are accepted. A
// negedge monitor pops and compares whenever the DUT completes a transfer.
// XZ is set to a defined byte so the idle-bus value is observable in 2-state sim.
module tb_zstr_fifo;

    localparam int unsigned BW = 8;
    localparam int unsigned QL = 4;
    localparam int unsigned CW = 3;
    localparam int unsigned AF = 3;
    localparam logic [BW-1:0] IDLE = 8'hEE;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_vld;
    logic [BW-1:0] s_bus;
    logic          s_rdy;
    logic          m_vld;
    logic [BW-1:0] m_bus;
    logic          m_rdy;
    logic [CW-1:0] cnt;
    logic          afull;

    int checks = 0;
    int errors = 0;
    logic [BW-1:0] sb [$];

    zstr_fifo #(
        .BW(BW), .XZ(IDLE), .QL(QL), .QW(2), .CW(CW), .AF(AF)
    ) dut (
        .clk(clk), .rst(rst),
        .s_vld(s_vld), .s_bus(s_bus), .s_rdy(s_rdy),
        .m_vld(m_vld), .m_bus(m_bus), .m_rdy(m_rdy),
        .cnt(cnt), .afull(afull)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle, then record the word if the vector says it is accepted.
    task automatic step(input logic vld, input logic [BW-1:0] data,
                        input logic rdy, input logic acc);
        s_vld = vld;
        s_bus = data;
        m_rdy = rdy;
        @(posedge clk);
        #1;
        if (acc) sb.push_back(data);
    endtask

    // Monitor: occupancy and valid track the scoreboard; data checked on pop.
    always @(negedge clk) begin
        if (!rst) begin
            chk("mon_cnt", 32'(cnt), 32'(sb.size()));
            chk("mon_m_vld", 32'(m_vld), 32'(sb.size() != 0));
            if (m_vld && m_rdy) begin
                if (sb.size() == 0) begin
                    chk("mon_unexpected_pop", 32'(m_bus), 32'hFFFF_FFFF);
                end else begin
                    chk("mon_m_bus", 32'(m_bus), 32'(sb.pop_front()));
                end
            end
        end
    end

    initial begin
        rst   = 1'b1;
        s_vld = 1'b1;
        s_bus = 8'h99;
        m_rdy = 1'b0;

        // Reset held two cycles with s_vld high.
        @(posedge clk); #1;
        chk("rst_s_rdy", 32'(s_rdy), 0);
        chk("rst_cnt", 32'(cnt), 0);
        chk("rst_m_vld", 32'(m_vld), 0);
        chk("rst_m_bus", 32'(m_bus), 32'(IDLE));
        @(posedge clk); #1;
        chk("rst_s_rdy2", 32'(s_rdy), 0);
        chk("rst_afull", 32'(afull), 0);
        rst   = 1'b0;
        s_vld = 1'b0;
        #1;
        chk("rel_s_rdy", 32'(s_rdy), 1);

        // Fill with drain stalled.
        step(1'b1, 8'h11, 1'b0, 1'b1);
        chk("fill1_cnt", 32'(cnt), 1); chk("fill1_afull", 32'(afull), 0);
        step(1'b1, 8'h22, 1'b0, 1'b1);
        chk("fill2_cnt", 32'(cnt), 2); chk("fill2_afull", 32'(afull), 0);
        step(1'b1, 8'h33, 1'b0, 1'b1);
        chk("fill3_cnt", 32'(cnt), 3); chk("fill3_afull", 32'(afull), 1);
        chk("fill3_s_rdy", 32'(s_rdy), 1);
        step(1'b1, 8'h44, 1'b0, 1'b1);
        chk("fill4_cnt", 32'(cnt), 4); chk("fill4_s_rdy", 32'(s_rdy), 0);
        step(1'b1, 8'h55, 1'b0, 1'b0);
        chk("fill5_cnt", 32'(cnt), 4); chk("fill5_head", 32'(m_bus), 32'h11);

        // Drain from full.
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("drain1_cnt", 32'(cnt), 3); chk("drain1_s_rdy", 32'(s_rdy), 1);
        chk("drain1_afull", 32'(afull), 1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("drain2_cnt", 32'(cnt), 2); chk("drain2_afull", 32'(afull), 0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("drain3_cnt", 32'(cnt), 1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("drain4_cnt", 32'(cnt), 0); chk("drain4_m_vld", 32'(m_vld), 0);
        chk("drain4_m_bus", 32'(m_bus), 32'(IDLE));

        // Streaming through the pointer wrap.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(i), 1'b1, 1'b1);
            chk("stream_cnt", 32'(cnt), 1);
            chk("stream_head", 32'(m_bus), 32'(i));
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("stream_end_cnt", 32'(cnt), 0);

        // Full with simultaneous push and pop: pop only.
        for (int i = 0; i < 4; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b1);
        chk("fs_full_cnt", 32'(cnt), 4);
        step(1'b1, 8'hB0, 1'b1, 1'b0);
        chk("fs_pop_cnt", 32'(cnt), 3); chk("fs_s_rdy", 32'(s_rdy), 1);
        step(1'b1, 8'hB0, 1'b0, 1'b1);
        chk("fs_push_cnt", 32'(cnt), 4);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("fs_empty_cnt", 32'(cnt), 0);

        // Reset mid-operation while pushing.
        step(1'b1, 8'hC1, 1'b0, 1'b1);
        step(1'b1, 8'hC2, 1'b0, 1'b1);
        chk("mr_pre_cnt", 32'(cnt), 2);
        rst = 1'b1;
        step(1'b1, 8'hC3, 1'b0, 1'b0);
        sb.delete();
        rst = 1'b0;
        chk("mr_cnt", 32'(cnt), 0); chk("mr_m_vld", 32'(m_vld), 0);
        step(1'b1, 8'hA5, 1'b0, 1'b1);
        chk("mr_push_cnt", 32'(cnt), 1); chk("mr_head", 32'(m_bus), 32'hA5);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("mr_end_cnt", 32'(cnt), 0);

        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("sb_drained", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/zstr_fifo.md
# zstr_fifo

Parametrised z-stream buffer inserted between a `zstr` source and drain. It accepts transfers on a slave z-stream port, stores up to `QL` words of `BW` bits, and replays them in order on a master z-stream port. It exposes occupancy and an almost-full flag for flow-control decisions upstream. Its purpose is to decouple source and drain back-pressure. It generalises the single-entry `zstr` queue to arbitrary width and depth, and adds a defined idle-bus value and status outputs.

## Interface

- `BW`, default 8: bus width of `s_bus`/`m_bus`.
- `XZ`, default `{BW{1'bx}}`: value driven on `m_bus` while `m_vld` is 0.
- `QL`, default 4: queue depth in words, QL ≥ 1.
- `QW`, default `$clog2(QL)`: storage address width; use 1 when QL = 1.
- `CW`, default `$clog2(QL+1)`: occupancy counter width.
- `AF`, default `QL-1`: almost-full threshold, 0 ≤ AF ≤ QL.

Ports (clock and reset first):

- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `s_vld` in 1: slave transfer valid.
- `s_bus` in BW: slave data.
- `s_rdy` out 1: slave ready.
- `m_vld` out 1: master transfer valid.
- `m_bus` out BW: master data.
- `m_rdy` in 1: master ready.
- `cnt` out CW: number of stored words, 0..QL.
- `afull` out 1: `cnt >= AF`.

## Operation

- Transfers:
  - Push = `s_vld & s_rdy`.
  - Pop = `m_vld & m_rdy`.
  - Each is sampled on the rising edge of `clk`.
- State:
  - Storage array of QL words.
  - Write pointer `wp` and read pointer `rp`, both QW bits.
  - Counter `cnt`.
- Push: `mem[wp] <= s_bus`; `wp` advances by 1 and wraps from QL-1 to 0. This is explicit wrap; do not rely on power-of-two overflow.
- Pop: `rp` advances with the same wrap rule.
- `cnt` update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on push and pop together, or on neither.
- Output and status decode:
  - `s_rdy = !rst & (cnt != QL)`. It depends only on registered state, with no combinational path from `m_rdy`.
  - `m_vld = (cnt != 0)`.
  - `m_bus = m_vld ? mem[rp] : XZ`.
  - `afull = (cnt >= AF)`.
- Full (cnt = QL): `s_rdy = 0`. A simultaneous pop this cycle does not enable a push; the freed slot becomes available the next cycle.
- Empty (cnt = 0): `m_vld = 0` and `m_bus = XZ`. There is no fall-through, so a push into an empty queue is visible on `m_vld` the next cycle.
- Push and pop in the same cycle with 0 < cnt < QL: both take effect and `cnt` is held.
- Source protocol: the source may drop `s_vld` or change `s_bus` at any time. Only edges where a push occurs are stored.
- Drain-side protocol: `m_bus` stays stable while `m_vld & !m_rdy`, because the head word is not overwritten while stored.
- Reset:
  - On an edge with `rst = 1`: `wp`, `rp` and `cnt` go to 0.
  - Stored words are discarded and memory contents are not cleared.
  - A push or pop in the same cycle as reset is ignored.
  - While `rst` is high, `s_rdy` is forced to 0.

## Timing

- Values after reset:
  - `cnt = 0`
  - `m_vld = 0`
  - `m_bus = XZ`
  - `afull = (AF == 0)`
  - `s_rdy = 1` from the first cycle with `rst = 0`.
- Latency: a push at edge N gives `m_vld = 1` with that data after edge N.
- Throughput: 1 word per cycle, sustained for any QL ≥ 2 when the drain keeps `m_rdy` at 1.
- QL = 1 alternates full and empty, giving 1 word per 2 cycles.
- `cnt`, `afull`, `s_rdy` and `m_vld` all change only after a clock edge. `m_bus` is a combinational read of registered state.

## Test plan

All scenarios use BW=8, QL=4, AF=3.

- **Reset:** hold `rst` 2 cycles with `s_vld=1` → `cnt=0`, `s_rdy=0` during reset, `m_vld=0`, `m_bus=8'hxx`. After release, `s_rdy=1`.
- **Fill:** push 8'h11, 22, 33, 44 with `m_rdy=0`.
  - `cnt` reads 1, 2, 3, 4.
  - `afull` rises when `cnt=3`.
  - `s_rdy=0` at `cnt=4`.
  - A fifth `s_vld` with 8'h55 is not stored.
- **Drain:** from full, `m_rdy=1` for 4 cycles.
  - `m_bus` reads 11, 22, 33, 44 in order, then `m_vld=0` and `m_bus=XZ`.
  - `s_rdy` returns to 1 one cycle after the first pop.
- **Streaming wrap:** continuous push 8'h00..8'h0F with `m_rdy=1`.
  - All 16 words arrive in order, one per cycle after the first.
  - `cnt` stays at 1 and the pointers wrap 4 times.
- **Full simultaneous:** at `cnt=4`, with `s_vld=1` and `m_rdy=1` for one cycle → pop only, `cnt=3`. The next cycle's push is accepted.
- **Reset mid-operation:** with `cnt=2`, assert `rst` for 1 cycle while pushing → `cnt=0`, `m_vld=0`. The next push of 8'hA5 is the first word out.
